// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for an RV32I subset (LOAD, STORE, OP-IMM, OP,
// JAL, JALR). Steps a shared memory port, IR, PC, ALU and register file through
// FETCH/DECODE/EXEC/MEM/WB, traps illegal opcodes and memory timeouts into a
// sticky HALT, and counts retired instructions.
module multicycle_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             jalr,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             bus_err,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_LOAD  = 3'd0,
    C_STORE = 3'd1,
    C_OPIMM = 3'd2,
    C_OP    = 3'd3,
    C_JAL   = 3'd4,
    C_JALR  = 3'd5,
    C_ILL   = 3'd6
  } class_t;

  // Last count value at which a request may still complete; reaching TIMEOUT
  // without ready is the bus error.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  function automatic class_t classify(input logic [6:0] opcode);
    case (opcode)
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010011: return C_OPIMM;
      7'b0110011: return C_OP;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_ILL;
    endcase
  endfunction

  state_t           state_q, state_d;
  class_t           cls_q;
  class_t           cls_dec;
  logic [7:0]       tmo_q;
  logic             tmo_hit;
  logic             ill_q, be_q;
  logic [CNT_W-1:0] instret_q;

  // Raw (ungated) control strobes from the decoder
  logic       req_c, we_c, irw_c, pcw_c, pcs_c, jalr_c, imm_c, rw_c, ret_c;
  logic [1:0] wb_c;

  assign cls_dec = classify(op);
  assign tmo_hit = (tmo_q == TMO_LAST);

  // State register; async reset restarts in FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and control decode from state, latched class and handshake
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    pcs_c   = 1'b0;
    jalr_c  = 1'b0;
    imm_c   = 1'b0;
    rw_c    = 1'b0;
    wb_c    = 2'b00;
    ret_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        state_d = (cls_dec == C_ILL) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        imm_c = (cls_q == C_LOAD) || (cls_q == C_STORE) ||
                (cls_q == C_OPIMM) || (cls_q == C_JALR);
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_OP, C_OPIMM:   state_d = S_WB;
          C_JAL, C_JALR: begin
            // Link value is the PC+4 captured at fetch, before this PC update
            pcw_c   = 1'b1;
            pcs_c   = 1'b1;
            jalr_c  = (cls_q == C_JALR);
            rw_c    = 1'b1;
            wb_c    = 2'b10;
            ret_c   = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        we_c  = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) begin
            ret_c   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rw_c    = 1'b1;
        wb_c    = (cls_q == C_LOAD) ? 2'b01 : 2'b00;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every strobe low at once, so an in-flight request is dropped
  // without waiting for a clock edge.
  assign mem_req     = req_c  & ~rst;
  assign mem_we      = we_c   & ~rst;
  assign ir_write    = irw_c  & ~rst;
  assign pc_write    = pcw_c  & ~rst;
  assign pc_sel      = pcs_c  & ~rst;
  assign jalr        = jalr_c & ~rst;
  assign alu_src_imm = imm_c  & ~rst;
  assign reg_write   = rw_c   & ~rst;
  assign wb_sel      = rst ? 2'b00 : wb_c;
  assign retire      = ret_c  & ~rst;
  assign instret     = instret_q;
  assign illegal     = ill_q;
  assign bus_err     = be_q;
  assign state       = state_q;

  // Opcode class is captured once, in DECODE, and used by EXEC/MEM/WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cls_q <= C_LOAD;
    else if (state_q == S_DECODE) cls_q <= cls_dec;
  end

  // Wait counter: cleared on every state change, counts unanswered request cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       tmo_q <= 8'd0;
    else if (state_d != state_q)   tmo_q <= 8'd0;
    else if (req_c && !mem_ready)  tmo_q <= tmo_q + 8'd1;
  end

  // Sticky trap flags, set on the transition into HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_q <= 1'b0;
      be_q  <= 1'b0;
    end else begin
      if (state_q == S_DECODE && cls_dec == C_ILL)
        ill_q <= 1'b1;
      if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && tmo_hit)
        be_q <= 1'b1;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret_q <= '0;
    else if (ret_c)  instret_q <= instret_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer. Each instruction is expanded by a
// transaction-level model into a per-cycle list of (inputs, expected outputs)
// from the instruction's opcode and memory wait counts; the list is then
// replayed against the DUT cycle by cycle.
module tb_multicycle_sequencer;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic             clk, rst;
  logic [6:0]       op;
  logic             mem_ready;
  logic             mem_req, mem_we, ir_write, pc_write, pc_sel, jalr;
  logic             alu_src_imm, reg_write, retire, illegal, bus_err;
  logic [1:0]       wb_sel;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state;

  multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_sel(pc_sel), .jalr(jalr),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .wb_sel(wb_sel),
    .retire(retire), .instret(instret), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dut_vec;
  assign dut_vec = {state, mem_req, mem_we, ir_write, pc_write, pc_sel, jalr,
                    alu_src_imm, reg_write, wb_sel, retire, illegal, bus_err};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic [6:0]  op;
    logic [15:0] vec;
    int          inst;
  } cyc_t;

  cyc_t q[$];
  int   inst_m;
  bit   ill_m, be_m, halted;

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic bit legal(input logic [6:0] o);
    return o == OP_LOAD || o == OP_STORE || o == OP_OPIMM ||
           o == OP_OP   || o == OP_JAL   || o == OP_JALR;
  endfunction

  task automatic push(input logic rdy, input logic [6:0] o, input logic [2:0] st,
                      input logic req, input logic we, input logic irw,
                      input logic pcw, input logic pcs, input logic jr,
                      input logic imm, input logic rw, input logic [1:0] wb,
                      input logic ret);
    cyc_t c;
    c.rdy  = rdy;
    c.op   = o;
    c.vec  = {st, req, we, irw, pcw, pcs, jr, imm, rw, wb, ret, ill_m, be_m};
    c.inst = inst_m;
    q.push_back(c);
    if (ret) inst_m++;
  endtask

  // Expand one instruction into expected cycles. fw/mw = wait cycles before
  // mem_ready in fetch / data access; TIMEOUT or more unanswered cycles trap.
  task automatic gen_instr(input logic [6:0] o, input int fw, input int mw);
    int  i;
    bit  ld, sto, jmp, isjr, imm;
    if (halted) return;
    i = 0;
    while (1) begin
      if (i == fw) begin
        push(1'b1, rop(), 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        break;
      end
      push(1'b0, rop(), 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
      i++;
      if (i == TIMEOUT) begin be_m = 1; halted = 1; return; end
    end
    push(rbit(), o, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    if (!legal(o)) begin ill_m = 1; halted = 1; return; end
    ld   = (o == OP_LOAD);
    sto  = (o == OP_STORE);
    isjr = (o == OP_JALR);
    jmp  = (o == OP_JAL) || isjr;
    imm  = ld || sto || isjr || (o == OP_OPIMM);
    if (jmp) begin
      push(rbit(), rop(), 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, isjr, imm, 1'b1, 2'b10, 1'b1);
      return;
    end
    push(rbit(), rop(), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, imm, 1'b0, 2'b00, 1'b0);
    if (ld || sto) begin
      i = 0;
      while (1) begin
        if (i == mw) begin
          push(1'b1, rop(), 3'd3, 1'b1, sto, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, sto);
          break;
        end
        push(1'b0, rop(), 3'd3, 1'b1, sto, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        i++;
        if (i == TIMEOUT) begin be_m = 1; halted = 1; return; end
      end
      if (sto) return;
    end
    push(rbit(), rop(), 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
         ld ? 2'b01 : 2'b00, 1'b1);
  endtask

  task automatic gen_halt(input int n);
    for (int k = 0; k < n; k++)
      push(rbit(), rop(), 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  // Replay n expected cycles; entered and left at a falling edge
  task automatic run_queue(input int n);
    cyc_t c;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      c = q.pop_front();
      mem_ready = c.rdy;
      op        = c.op;
      #1;
      check("cycle_outputs", 32'(dut_vec), 32'(c.vec));
      check("cycle_instret", 32'(instret), 32'(c.inst % (1 << CNT_W)));
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("reset_outputs", 32'(dut_vec), 32'd0);
    check("reset_instret", 32'(instret), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    inst_m = 0; ill_m = 0; be_m = 0; halted = 0;
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [6];
    ops = '{OP_LOAD, OP_STORE, OP_OPIMM, OP_OP, OP_JAL, OP_JALR};
    if ($urandom_range(0, 9) == 0) return rop();
    return ops[$urandom_range(0, 5)];
  endfunction

  function automatic int rand_wait();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(TIMEOUT, TIMEOUT + 2));
    return int'($urandom_range(0, TIMEOUT - 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; op = 7'd0;
    inst_m = 0; ill_m = 0; be_m = 0; halted = 0;
    @(negedge clk);
    apply_reset();

    // ADDI, zero-wait memory
    gen_instr(OP_OPIMM, 0, 0);
    run_queue(q.size());
    check("addi_instret", 32'(instret), 32'd1);

    // LOAD with 3 data wait cycles, then STORE and JALR
    gen_instr(OP_LOAD, 0, 3);
    gen_instr(OP_STORE, 0, 0);
    gen_instr(OP_JALR, 1, 0);
    gen_instr(OP_OP, 2, 0);
    gen_instr(OP_JAL, 0, 0);
    run_queue(q.size());
    check("seq_instret", 32'(instret), 32'd6);

    // Illegal opcode traps and holds for 20 cycles
    gen_instr(OP_SYS, 0, 0);
    gen_halt(20);
    run_queue(q.size());
    check("illegal_flag", 32'(illegal), 32'd1);
    apply_reset();

    // Fetch timeout, then ready exactly on the last allowed cycle
    gen_instr(OP_OPIMM, TIMEOUT + 3, 0);
    gen_halt(5);
    run_queue(q.size());
    check("bus_err_flag", 32'(bus_err), 32'd1);
    apply_reset();
    gen_instr(OP_OPIMM, TIMEOUT - 1, 0);
    gen_instr(OP_LOAD, 0, TIMEOUT - 1);
    run_queue(q.size());
    check("boundary_no_err", 32'(bus_err), 32'd0);

    // Data-access timeout
    gen_instr(OP_STORE, 0, TIMEOUT);
    gen_halt(3);
    run_queue(q.size());
    apply_reset();

    // Asynchronous reset in the middle of a STORE data access
    gen_instr(OP_OPIMM, 0, 0);
    gen_instr(OP_STORE, 0, 3);
    run_queue(q.size() - 2);
    mem_ready = 1'b0;
    #1;
    check("pre_rst_mem_req", 32'(mem_req), 32'd1);
    check("pre_rst_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_mem_we", 32'(mem_we), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_instret", 32'(instret), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    inst_m = 0; ill_m = 0; be_m = 0; halted = 0;

    // Counter wrap
    for (int k = 0; k < 18; k++) gen_instr(OP_JAL, 0, 0);
    run_queue(q.size());
    check("wrap_instret", 32'(instret), 32'(18 % (1 << CNT_W)));

    // Random programs
    for (int t = 0; t < 30; t++) begin
      apply_reset();
      for (int k = 0; k < 8 && !halted; k++) gen_instr(rand_op(), rand_wait(), rand_wait());
      if (halted) gen_halt(int'($urandom_range(1, 10)));
      run_queue(q.size());
      check("rand_instret", 32'(instret), 32'(inst_m % (1 << CNT_W)));
      check("rand_flags", 32'({illegal, bus_err}), 32'({ill_m, be_m}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
